nonce_tx_queue: RTL and testbench



---
 rtl/nonce_tx_queue.sv | 186 ++++++++++++++++++
 tb/tb_nonce_tx_queue.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_tx_queue.sv
// nonce_tx_queue: buffers 64-bit nonces from the hash core in a small FIFO
// and serializes each one, little-endian, into bytes for the UART TX.
// Optional macro NONCE_TX_FRAME_EN: wraps each nonce as a 10-byte frame
// (sync 0xA5, 8 nonce bytes, XOR checksum). Undefined: 8 raw bytes.
//
// TX handshake: a byte moves on every rising edge where TxValid && TxReady.
// Once TxValid rises it stays high with TxByte held until the last byte of
// the frame is accepted; TxValid never depends combinationally on TxReady.
module nonce_tx_queue #(
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                NonceFound,
  input  logic [63:0]         NonceIn,
  input  logic                WorkFlush,
  output logic [7:0]          TxByte,
  output logic                TxValid,
  input  logic                TxReady,
  output logic                Overflow,
  output logic [LOG2_DEPTH:0] Count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

`ifdef NONCE_TX_FRAME_EN
  localparam logic [3:0] LAST_IDX  = 4'd9;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
`else
  localparam logic [3:0] LAST_IDX  = 4'd7;
`endif
  localparam logic [LOG2_DEPTH:0] FULL_CNT = (LOG2_DEPTH + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [63:0]           mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  push;
  logic                  pop;
  logic [63:0]           head;

  // Serializer state; outputs are registered
  state_e                state_q, state_d;
  logic [63:0]           shift_q, shift_d;
  logic [3:0]            idx_q, idx_d;
  logic [7:0]            tx_byte_q, tx_byte_d;
  logic                  tx_valid_q, tx_valid_d;
`ifdef NONCE_TX_FRAME_EN
  logic [7:0]            chk_q, chk_d;

  function automatic logic [7:0] xor_bytes(input logic [63:0] v);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 8; k++) acc = acc ^ v[8*k +: 8];
    return acc;
  endfunction
`endif

  assign head = mem_q[rd_ptr_q];

  // Serializer: pop the head in IDLE, walk the bytes in SEND
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    tx_byte_d  = tx_byte_q;
    tx_valid_d = tx_valid_q;
    pop        = 1'b0;
`ifdef NONCE_TX_FRAME_EN
    chk_d      = chk_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // A flush in the same cycle empties the queue, so it blocks the pop.
        if ((count_q != '0) && !WorkFlush) begin
          pop        = 1'b1;
          state_d    = ST_SEND;
          idx_d      = 4'd0;
          tx_valid_d = 1'b1;
`ifdef NONCE_TX_FRAME_EN
          tx_byte_d  = SYNC_BYTE;
          shift_d    = head;
          chk_d      = xor_bytes(head);
`else
          tx_byte_d  = head[7:0];
          shift_d    = {8'h00, head[63:8]};
`endif
        end
      end
      ST_SEND: begin
        if (TxReady) begin
          if (idx_q == LAST_IDX) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
          end else begin
            idx_d = idx_q + 4'd1;
`ifdef NONCE_TX_FRAME_EN
            if (idx_q == LAST_IDX - 4'd1) begin
              tx_byte_d = chk_q;
            end else begin
              tx_byte_d = shift_q[7:0];
              shift_d   = {8'h00, shift_q[63:8]};
            end
`else
            tx_byte_d = shift_q[7:0];
            shift_d   = {8'h00, shift_q[63:8]};
`endif
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // FIFO next-state: flush beats push and pop; a full FIFO still accepts a
  // push when the serializer pops in the same cycle
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push       = NonceFound && !WorkFlush && ((count_q != FULL_CNT) || pop);
    if (WorkFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + LOG2_DEPTH'(1);
      if (push && !pop)      count_d = count_q + (LOG2_DEPTH + 1)'(1);
      else if (pop && !push) count_d = count_q - (LOG2_DEPTH + 1)'(1);
      if (NonceFound && !push) overflow_d = 1'b1;
    end
  end

  // Nonce storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= NonceIn;
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      tx_byte_q  <= '0;
      tx_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
`ifdef NONCE_TX_FRAME_EN
      chk_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      tx_byte_q  <= tx_byte_d;
      tx_valid_q <= tx_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
`ifdef NONCE_TX_FRAME_EN
      chk_q      <= chk_d;
`endif
    end
  end

  assign TxByte   = tx_byte_q;
  assign TxValid  = tx_valid_q;
  assign Overflow = overflow_q;
  assign Count    = count_q;

endmodule

// File: tb/tb_nonce_tx_queue.sv
// Directed bench for nonce_tx_queue with a byte scoreboard.
// Build with +define+NONCE_TX_FRAME_EN to exercise the framed format.
module tb_nonce_tx_queue;

  localparam int DEPTH      = 4;
  localparam int LOG2_DEPTH = 2;
`ifdef NONCE_TX_FRAME_EN
  localparam int         FRAME_LEN  = 10;
  localparam logic [7:0] FIRST_BYTE = 8'hA5;
`else
  localparam int         FRAME_LEN  = 8;
  localparam logic [7:0] FIRST_BYTE = 8'hEF;
`endif

  logic                clk = 1'b0;
  logic                nRst = 1'b0;
  logic                NonceFound = 1'b0;
  logic [63:0]         NonceIn = '0;
  logic                WorkFlush = 1'b0;
  logic                TxReady = 1'b0;
  logic [7:0]          TxByte;
  logic                TxValid;
  logic                Overflow;
  logic [LOG2_DEPTH:0] Count;

  nonce_tx_queue #(.DEPTH(DEPTH), .LOG2_DEPTH(LOG2_DEPTH)) dut (
    .clk        (clk),
    .nRst       (nRst),
    .NonceFound (NonceFound),
    .NonceIn    (NonceIn),
    .WorkFlush  (WorkFlush),
    .TxByte     (TxByte),
    .TxValid    (TxValid),
    .TxReady    (TxReady),
    .Overflow   (Overflow),
    .Count      (Count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];

  bit         mon_en         = 1'b0;
  int         bytes_in_frame = 0;
  bit         prev_stall     = 1'b0;
  logic [7:0] prev_byte      = '0;
  bit         gap_pend       = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] n);
    logic [7:0] x;
    x = 8'h00;
`ifdef NONCE_TX_FRAME_EN
    exp_q.push_back(8'hA5);
`endif
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(n[8*k +: 8]);
      x = x ^ n[8*k +: 8];
    end
`ifdef NONCE_TX_FRAME_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic push_nonce(input logic [63:0] n, input bit accept);
    NonceIn    = n;
    NonceFound = 1'b1;
    if (accept) push_exp(n);
    tick();
    NonceFound = 1'b0;
  endtask

  // mode 0: ready always, 1: pattern 1,0,0,1, 2: random
  task automatic drain(input int mode);
    int budget;
    int cyc;
    budget = 3000;
    cyc    = 0;
    while ((exp_q.size() != 0 || TxValid) && budget > 0) begin
      case (mode)
        0:       TxReady = 1'b1;
        1:       TxReady = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: TxReady = 1'($urandom_range(0, 1));
      endcase
      tick();
      budget--;
      cyc++;
    end
    vectors++;
    assert (budget > 0) else begin
      miscompares++;
      $error("FAIL drain_timeout: %0d bytes left, expected 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    exp_q.delete();
    nRst = 1'b0;
    tick();
    chk("rst_txvalid", TxValid, 1'b0);
    chk("rst_txbyte", TxByte, 8'h00);
    chk("rst_overflow", Overflow, 1'b0);
    chk("rst_count", Count, 0);
    nRst = 1'b1;
    tick();
    mon_en = 1'b1;
  endtask

  // Output monitor: scoreboard pops, stall stability, no mid-frame drop, frame gap
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", TxValid, 1'b1);
        chk("stall_byte", TxByte, prev_byte);
      end
      if (gap_pend) begin
        chk("frame_gap", TxValid, 1'b0);
        gap_pend = 1'b0;
      end else if (bytes_in_frame != 0) begin
        chk("valid_hold", TxValid, 1'b1);
      end
      prev_stall = TxValid && !TxReady;
      prev_byte  = TxByte;
      if (TxValid && TxReady) begin
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_byte: got %0h expected no byte", TxByte);
        end
        if (exp_q.size() != 0) chk("tx_byte", TxByte, exp_q.pop_front());
        bytes_in_frame++;
        if (bytes_in_frame == FRAME_LEN) begin
          bytes_in_frame = 0;
          gap_pend       = 1'b1;
        end
      end
    end else begin
      prev_stall     = 1'b0;
      gap_pend       = 1'b0;
      bytes_in_frame = 0;
    end
  end

  initial begin
    // Reset state
    do_reset();

    // Empty-FIFO latency and byte order
    TxReady = 1'b1;
    push_nonce(64'h0123456789ABCDEF, 1'b1);
    chk("lat_count_n1", Count, 1);
    chk("lat_valid_n1", TxValid, 1'b0);
    tick();
    chk("lat_valid_n2", TxValid, 1'b1);
    chk("lat_byte0_n2", TxByte, FIRST_BYTE);
    chk("lat_count_n2", Count, 0);
    drain(0);
    push_nonce(64'h00000000000000FF, 1'b1);
    drain(0);

    // Backpressure 1,0,0,1
    push_nonce({$urandom, $urandom}, 1'b1);
    drain(1);

    // Burst while stalled, then overflow
    TxReady = 1'b0;
    for (int i = 1; i <= 5; i++) push_nonce(64'(i), 1'b1);
    chk("burst_count", Count, 4);
    chk("burst_no_ovf", Overflow, 1'b0);
    push_nonce(64'd6, 1'b0);
    chk("ovf_set", Overflow, 1'b1);
    chk("ovf_count", Count, 4);
    drain(0);
    chk("burst_drained", Count, 0);

    // Mid-frame flush with 3 queued, combined with a same-cycle push
    TxReady = 1'b0;
    push_nonce(64'hA1A2A3A4A5A6A7A8, 1'b1);
    push_nonce(64'h11, 1'b0);
    push_nonce(64'h22, 1'b0);
    push_nonce(64'h33, 1'b0);
    chk("flush_pre_count", Count, 3);
    TxReady = 1'b1;
    tick();
    tick();
    WorkFlush  = 1'b1;
    NonceFound = 1'b1;
    NonceIn    = 64'hDEAD;
    tick();
    WorkFlush  = 1'b0;
    NonceFound = 1'b0;
    chk("flush_count", Count, 0);
    chk("flush_frame_alive", TxValid, 1'b1);
    chk("flush_ovf_kept", Overflow, 1'b1);
    drain(1);
    TxReady = 1'b1;
    repeat (5) tick();
    chk("flush_idle_valid", TxValid, 1'b0);
    chk("flush_idle_count", Count, 0);

    // Flush in IDLE with one queued: no pop
    TxReady    = 1'b0;
    NonceIn    = 64'h77;
    NonceFound = 1'b1;
    tick();
    NonceFound = 1'b0;
    WorkFlush  = 1'b1;
    tick();
    WorkFlush  = 1'b0;
    chk("idle_flush_count", Count, 0);
    chk("idle_flush_valid", TxValid, 1'b0);
    TxReady = 1'b1;
    repeat (4) tick();
    chk("idle_flush_quiet", TxValid, 1'b0);

    // Clear Overflow, then push and pop together while full
    do_reset();
    TxReady = 1'b0;
    for (int i = 0; i < 5; i++) push_nonce(64'h100 + 64'(i), 1'b1);
    chk("full_count", Count, 4);
    TxReady = 1'b1;
    repeat (FRAME_LEN) tick();
    push_nonce(64'h1FF, 1'b1);
    chk("pushpop_count", Count, 4);
    chk("pushpop_no_ovf", Overflow, 1'b0);
    chk("pushpop_valid", TxValid, 1'b1);
    drain(0);

    // Random nonces, random ready, never full
    for (int i = 0; i < 3; i++) begin
      push_nonce({$urandom, $urandom}, 1'b1);
      repeat ($urandom_range(0, 5)) begin
        TxReady = 1'($urandom_range(0, 1));
        tick();
      end
    end
    drain(2);

    // Reset during byte 3 of a frame
    TxReady = 1'b1;
    push_nonce(64'hCAFEBABE12345678, 1'b1);
    repeat (4) tick();
    chk("midrst_busy", TxValid, 1'b1);
    do_reset();
    TxReady = 1'b1;
    push_nonce(64'h0F1E2D3C4B5A6978, 1'b1);
    tick();
    chk("post_rst_byte0", TxByte, FIRST_BYTE == 8'hA5 ? 8'hA5 : 8'h78);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
